// File: rtl/ring_johnson_checker_pkg.sv
// Shared types and index-width helpers for the ring/Johnson counter checker.
package ring_johnson_checker_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StTrack,
    StLocked
  } state_e;

  function automatic int unsigned ring_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned john_idx_w(input int unsigned n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/ring_johnson_checker_johnson_decode.sv
// Combinational Johnson (twisted-ring) code decoder: legality check and 0..2N-1 index.
module johnson_decode
  import ring_johnson_checker_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned JW = john_idx_w(N)
) (
  input  logic [N-1:0]  john_i,
  output logic          legal_o,
  output logic [JW-1:0] idx_o
);

  localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] low_run;
  int unsigned  ones;

  always_comb begin
    ones = 0;
    for (int i = 0; i < N; i++) begin
      ones = ones + 32'(john_i[i]);
    end
    // MSB-anchored runs become LSB-anchored after inversion; both must be 2^k-1.
    low_run = john_i[N-1] ? ~john_i : john_i;
    legal_o = ((low_run & (low_run + One)) == '0);
    if (!legal_o) begin
      idx_o = '0;
    end else if (john_i[N-1]) begin
      idx_o = JW'(2 * N - ones);
    end else begin
      idx_o = JW'(ones);
    end
  end

endmodule

// File: rtl/ring_johnson_checker.sv
// Receive-side monitor: decodes ring and Johnson samples, tracks step-by-one
// sequencing, maintains lock and a saturating error count.
module ring_johnson_checker
  import ring_johnson_checker_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [N-1:0]             ring_in,
  input  logic [N-1:0]             john_in,
  output logic [ring_idx_w(N)-1:0] ring_idx,
  output logic [john_idx_w(N)-1:0] john_idx,
  output logic                     ring_legal,
  output logic                     john_legal,
  output logic                     locked,
  output logic                     err_pulse,
  output logic [ERR_W-1:0]         err_count
);

  localparam int unsigned RW = ring_idx_w(N);
  localparam int unsigned JW = john_idx_w(N);
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [RW-1:0]  ring_idx_q, ring_idx_d, prev_ring_q, prev_ring_d;
  logic [JW-1:0]  john_idx_q, john_idx_d, prev_john_q, prev_john_d;
  logic           ring_legal_q, ring_legal_d, john_legal_q, john_legal_d;
  logic           err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [GW-1:0]  good_run_q, good_run_d;

  logic          ring_ok, john_ok, both_ok, good;
  logic [RW-1:0] ring_dec, ring_next;
  logic [JW-1:0] john_dec, john_next;
  logic [GW-1:0] run_next;

  johnson_decode #(
    .N(N)
  ) u_john_dec (
    .john_i (john_in),
    .legal_o(john_ok),
    .idx_o  (john_dec)
  );

  always_comb begin
    ring_ok  = (ring_in != '0) && ((ring_in & (ring_in - One)) == '0);
    ring_dec = '0;
    for (int i = 0; i < N; i++) begin
      if (ring_in[i] && ring_ok) ring_dec = RW'(i);
    end
  end

  always_comb begin
    ring_next = (prev_ring_q == RW'(N - 1)) ? '0 : RW'(32'(prev_ring_q) + 1);
    john_next = (prev_john_q == JW'(2 * N - 1)) ? '0 : JW'(32'(prev_john_q) + 1);
    run_next  = GW'(32'(good_run_q) + 1);
    both_ok   = ring_ok && john_ok;
    good      = both_ok && (ring_dec == ring_next) && (john_dec == john_next);

    state_d      = state_q;
    ring_idx_d   = ring_idx_q;
    john_idx_d   = john_idx_q;
    ring_legal_d = ring_legal_q;
    john_legal_d = john_legal_q;
    prev_ring_d  = prev_ring_q;
    prev_john_d  = prev_john_q;
    good_run_d   = good_run_q;
    err_count_d  = err_count_q;
    err_pulse_d  = 1'b0;

    if (sample_en) begin
      ring_idx_d   = ring_dec;
      john_idx_d   = john_dec;
      ring_legal_d = ring_ok;
      john_legal_d = john_ok;
      if (both_ok) begin
        prev_ring_d = ring_dec;
        prev_john_d = john_dec;
      end
      case (state_q)
        StHunt: begin
          if (both_ok) begin
            good_run_d = '0;
            state_d    = StTrack;
          end
        end
        StTrack: begin
          if (good) begin
            good_run_d = run_next;
            if (run_next == GW'(LOCK_CNT)) state_d = StLocked;
          end else if (both_ok) begin
            good_run_d = '0;
          end else begin
            state_d = StHunt;
          end
        end
        StLocked: begin
          if (!good) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            good_run_d = '0;
            state_d    = both_ok ? StTrack : StHunt;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StHunt;
      ring_idx_q   <= '0;
      john_idx_q   <= '0;
      ring_legal_q <= 1'b0;
      john_legal_q <= 1'b0;
      prev_ring_q  <= '0;
      prev_john_q  <= '0;
      good_run_q   <= '0;
      err_count_q  <= '0;
      err_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_idx_q   <= ring_idx_d;
      john_idx_q   <= john_idx_d;
      ring_legal_q <= ring_legal_d;
      john_legal_q <= john_legal_d;
      prev_ring_q  <= prev_ring_d;
      prev_john_q  <= prev_john_d;
      good_run_q   <= good_run_d;
      err_count_q  <= err_count_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  assign ring_idx   = ring_idx_q;
  assign john_idx   = john_idx_q;
  assign ring_legal = ring_legal_q;
  assign john_legal = john_legal_q;
  assign locked     = (state_q == StLocked);
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_ring_johnson_checker.sv
// Directed self-checking bench for ring_johnson_checker (N=4, LOCK_CNT=2, ERR_W=2).
module tb_ring_johnson_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [3:0] ring_in, john_in;
  logic [1:0] ring_idx;
  logic [2:0] john_idx;
  logic       ring_legal, john_legal, locked, err_pulse;
  logic [1:0] err_count;

  int checks = 0;
  int errors = 0;
  int pos = 0;

  ring_johnson_checker #(
    .N(4),
    .LOCK_CNT(2),
    .ERR_W(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .ring_in   (ring_in),
    .john_in   (john_in),
    .ring_idx  (ring_idx),
    .john_idx  (john_idx),
    .ring_legal(ring_legal),
    .john_legal(john_legal),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ring_code(input int k);
    logic [3:0] t;
    t = 4'b0001;
    return t << (k % 4);
  endfunction

  // Johnson table: 0000 0001 0011 0111 1111 1110 1100 1000
  function automatic logic [3:0] john_code(input int k);
    int m;
    logic [3:0] t;
    m = k % 8;
    if (m <= 4) begin
      t = 4'b0000;
      for (int i = 0; i < m; i++) t[i] = 1'b1;
    end else begin
      t = 4'b1111;
      t = t << (m - 4);
    end
    return t;
  endfunction

  task automatic send(input logic [3:0] r, input logic [3:0] j);
    @(negedge clk);
    sample_en = 1'b1;
    ring_in   = r;
    john_in   = j;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic send_pos();
    send(ring_code(pos), john_code(pos));
    pos++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_en = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_en = 1'b1;
    ring_in = 4'b0001;
    john_in = 4'b0000;
    @(posedge clk);
    #1;
    checks++;
    if ({ring_idx, john_idx, ring_legal, john_legal, locked, err_pulse, err_count} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ri=%0d ji=%0d rl=%0b jl=%0b lk=%0b ep=%0b ec=%0d want all 0",
               ring_idx, john_idx, ring_legal, john_legal, locked, err_pulse, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
    sample_en = 1'b0;
    pos = 0;
  endtask

  task automatic test_lock();
    for (int k = 0; k < 9; k++) begin
      send_pos();
      checks++;
      if (ring_idx !== 2'(k % 4) || john_idx !== 3'(k % 8) || ring_legal !== 1'b1 ||
          john_legal !== 1'b1) begin
        errors++;
        $display("FAIL lock_decode k=%0d: got ri=%0d ji=%0d rl=%0b jl=%0b want ri=%0d ji=%0d legal 1",
                 k, ring_idx, john_idx, ring_legal, john_legal, k % 4, k % 8);
      end
      checks++;
      if (locked !== (k >= 2) || err_pulse !== 1'b0) begin
        errors++;
        $display("FAIL lock_state k=%0d: got lk=%0b ep=%0b want lk=%0b ep=0",
                 k, locked, err_pulse, k >= 2);
      end
    end
    checks++;
    if (err_count !== 2'd0) begin
      errors++;
      $display("FAIL lock_errcount: got %0d want 0", err_count);
    end
  endtask

  task automatic test_stall();
    send(ring_code(pos - 1), john_code(pos - 1));
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 2'd1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL stall_err: got ep=%0b ec=%0d lk=%0b want ep=1 ec=1 lk=0",
               err_pulse, err_count, locked);
    end
    send_pos();
    checks++;
    if (err_pulse !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL stall_track: got ep=%0b lk=%0b want ep=0 lk=0", err_pulse, locked);
    end
    send_pos();
    checks++;
    if (locked !== 1'b1 || err_count !== 2'd1) begin
      errors++;
      $display("FAIL stall_relock: got lk=%0b ec=%0d want lk=1 ec=1", locked, err_count);
    end
  endtask

  task automatic test_illegal();
    send(4'b0110, john_code(pos));
    pos++;
    checks++;
    if (err_pulse !== 1'b1 || ring_legal !== 1'b0 || ring_idx !== 2'd0 || john_legal !== 1'b1 ||
        john_idx !== 3'd3 || locked !== 1'b0 || err_count !== 2'd2) begin
      errors++;
      $display("FAIL illegal_ring: got ep=%0b rl=%0b ri=%0d jl=%0b ji=%0d lk=%0b ec=%0d want 1 0 0 1 3 0 2",
               err_pulse, ring_legal, ring_idx, john_legal, john_idx, locked, err_count);
    end
    // From HUNT it takes three samples to lock again.
    for (int k = 0; k < 3; k++) begin
      send_pos();
      checks++;
      if (locked !== (k == 2) || err_pulse !== 1'b0) begin
        errors++;
        $display("FAIL illegal_ring_relock k=%0d: got lk=%0b ep=%0b want lk=%0b ep=0",
                 k, locked, err_pulse, k == 2);
      end
    end
    send(ring_code(pos), 4'b0101);
    pos++;
    checks++;
    if (err_pulse !== 1'b1 || john_legal !== 1'b0 || john_idx !== 3'd0 || ring_legal !== 1'b1 ||
        ring_idx !== 2'd3 || locked !== 1'b0 || err_count !== 2'd3) begin
      errors++;
      $display("FAIL illegal_john: got ep=%0b jl=%0b ji=%0d rl=%0b ri=%0d lk=%0b ec=%0d want 1 0 0 1 3 0 3",
               err_pulse, john_legal, john_idx, ring_legal, ring_idx, locked, err_count);
    end
    for (int k = 0; k < 3; k++) begin
      send_pos();
      checks++;
      if (locked !== (k == 2)) begin
        errors++;
        $display("FAIL illegal_john_relock k=%0d: got lk=%0b want %0b", k, locked, k == 2);
      end
    end
  endtask

  task automatic test_gaps();
    for (int g = 1; g <= 5; g++) begin
      for (int c = 0; c < g; c++) begin
        @(negedge clk);
        sample_en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ring_idx !== 2'((pos - 1) % 4) || john_idx !== 3'((pos - 1) % 8) || locked !== 1'b1 ||
            err_pulse !== 1'b0 || ring_legal !== 1'b1 || john_legal !== 1'b1) begin
          errors++;
          $display("FAIL gap_hold g=%0d: got ri=%0d ji=%0d lk=%0b ep=%0b want ri=%0d ji=%0d lk=1 ep=0",
                   g, ring_idx, john_idx, locked, err_pulse, (pos - 1) % 4, (pos - 1) % 8);
        end
      end
      send_pos();
      checks++;
      if (john_idx !== 3'((pos - 1) % 8) || locked !== 1'b1 || err_pulse !== 1'b0) begin
        errors++;
        $display("FAIL gap_sample g=%0d: got ji=%0d lk=%0b ep=%0b want ji=%0d lk=1 ep=0",
                 g, john_idx, locked, err_pulse, (pos - 1) % 8);
      end
    end
    checks++;
    if (err_count !== 2'd3) begin
      errors++;
      $display("FAIL gap_errcount: got %0d want 3", err_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    checks++;
    if (err_count !== 2'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL sat_reset: got ec=%0d lk=%0b want 0 0", err_count, locked);
    end
    repeat (3) send_pos();
    for (int e = 0; e < 5; e++) begin
      send(ring_code(pos - 1), john_code(pos - 1));
      checks++;
      if (err_pulse !== 1'b1 || err_count !== 2'((e + 1 > 3) ? 3 : e + 1)) begin
        errors++;
        $display("FAIL sat_count e=%0d: got ep=%0b ec=%0d want ep=1 ec=%0d",
                 e, err_pulse, err_count, (e + 1 > 3) ? 3 : e + 1);
      end
      repeat (2) send_pos();
      checks++;
      if (locked !== 1'b1) begin
        errors++;
        $display("FAIL sat_relock e=%0d: got lk=%0b want 1", e, locked);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) send_pos();
    for (int e = 0; e < 2; e++) begin
      send(ring_code(pos - 1), john_code(pos - 1));
      repeat (2) send_pos();
    end
    checks++;
    if (err_count !== 2'd2 || locked !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got ec=%0d lk=%0b want 2 1", err_count, locked);
    end
    @(negedge clk);
    rst = 1'b1;
    sample_en = 1'b1;
    ring_in = ring_code(pos);
    john_in = john_code(pos);
    @(posedge clk);
    #1;
    checks++;
    if ({ring_idx, john_idx, ring_legal, john_legal, locked, err_pulse, err_count} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset: got ri=%0d ji=%0d rl=%0b jl=%0b lk=%0b ep=%0b ec=%0d want all 0",
               ring_idx, john_idx, ring_legal, john_legal, locked, err_pulse, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
    sample_en = 1'b0;
    pos = 5;
    for (int k = 0; k < 3; k++) begin
      send_pos();
      checks++;
      if (locked !== (k == 2) || err_pulse !== 1'b0) begin
        errors++;
        $display("FAIL mid_hunt k=%0d: got lk=%0b ep=%0b want lk=%0b ep=0",
                 k, locked, err_pulse, k == 2);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sample_en = 1'b0;
    ring_in = 4'b0000;
    john_in = 4'b0000;
    test_reset();
    test_lock();
    test_stall();
    test_illegal();
    test_gaps();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
